// File: rtl/adder_datapath_seq.sv
// adder_datapath_seq: handshaked WIDTH-bit adder with a bit-serial ripple
// engine and a single-cycle carry-lookahead engine.
// S layout: [WIDTH:0] ripple sum, [2*WIDTH+1:WIDTH+1] lookahead sum; each
// sum is {carry-out, WIDTH-bit sum}; an unused half is always zero.
// Optional feature: define ADDER_XCHECK_EN to compare the two engines in
// mode 10 and report disagreement on mismatch.
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready; in_ready is high whenever the FSM is IDLE, so a new
// operation may be accepted in the same cycle out_valid pulses.
module adder_datapath_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Cin,
  output logic [2*WIDTH+1:0]   S,
  output logic                 out_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count,
  output logic                 mismatch,
  output logic                 dbg_state_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] ZERO_SUM = '0;

  typedef enum logic {ST_IDLE, ST_SERIAL} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q, racc_q;
  logic                cin_q, carry_q, la_pend_q, out_valid_q;
  logic [1:0]          mode_q;
  logic [IW-1:0]       idx_q;
  logic [2*WIDTH+1:0]  s_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [WIDTH:0]      la_sum_d, rip_sum_d, la_carry;
  logic [WIDTH-1:0]    racc_d, la_g, la_p;
  logic                bit_a, bit_b, bit_s_d, bit_co_d, last_bit, prod, cterm;

  // Carry-lookahead engine on the captured operands: every carry is a flat
  // sum of generate terms gated by the propagate products above them.
  always_comb begin
    la_g     = a_q & b_q;
    la_p     = a_q ^ b_q;
    la_carry = '0;
    prod     = 1'b1;
    cterm    = 1'b0;
    la_carry[0] = cin_q;
    for (int i = 0; i < WIDTH; i++) begin
      prod  = 1'b1;
      cterm = 1'b0;
      for (int j = i; j >= 0; j--) begin
        cterm = cterm | (prod & la_g[j]);
        prod  = prod & la_p[j];
      end
      cterm = cterm | (prod & cin_q);
      la_carry[i+1] = cterm;
    end
    la_sum_d = {la_carry[WIDTH], la_p ^ la_carry[WIDTH-1:0]};
  end

  // Ripple engine: one full-adder bit per SERIAL cycle; the final bit is
  // folded in combinationally so S can load on the bit WIDTH-1 edge.
  always_comb begin
    bit_a    = a_q[idx_q];
    bit_b    = b_q[idx_q];
    bit_s_d  = bit_a ^ bit_b ^ carry_q;
    bit_co_d = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    racc_d   = racc_q;
    racc_d[idx_q] = bit_s_d;
    rip_sum_d = {bit_co_d, racc_d};
    last_bit  = (idx_q == IW'(WIDTH - 1));
  end

`ifdef ADDER_XCHECK_EN
  logic mismatch_q;
`endif

  // Control FSM, operand capture, serial state and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      mode_q      <= 2'b00;
      la_pend_q   <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      racc_q      <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
`ifdef ADDER_XCHECK_EN
      mismatch_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      la_pend_q   <= 1'b0;
      // A lookahead op accepted on the previous edge completes here; the
      // operand registers may be overwritten by a new accept on this edge.
      if (la_pend_q) begin
        s_q         <= {la_sum_d, ZERO_SUM};
        out_valid_q <= 1'b1;
        cnt_q       <= cnt_q + CNT_W'(1);
`ifdef ADDER_XCHECK_EN
        mismatch_q  <= 1'b0;
`endif
      end
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q    <= A;
            b_q    <= B;
            cin_q  <= Cin;
            mode_q <= mode;
            if (mode[0]) begin
              la_pend_q <= 1'b1;
            end else begin
              state_q <= ST_SERIAL;
              idx_q   <= '0;
              carry_q <= Cin;
              racc_q  <= '0;
            end
          end
        end
        ST_SERIAL: begin
          racc_q  <= racc_d;
          carry_q <= bit_co_d;
          idx_q   <= idx_q + IW'(1);
          if (last_bit) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            s_q         <= {(mode_q == 2'b10) ? la_sum_d : ZERO_SUM, rip_sum_d};
            out_valid_q <= 1'b1;
            cnt_q       <= cnt_q + CNT_W'(1);
`ifdef ADDER_XCHECK_EN
            mismatch_q  <= (mode_q == 2'b10) && (rip_sum_d != la_sum_d);
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_SERIAL);
  assign dbg_state_o = state_q;
  assign S           = s_q;
  assign out_valid   = out_valid_q;
  assign op_count    = cnt_q;
`ifdef ADDER_XCHECK_EN
  assign mismatch    = mismatch_q;
`else
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_adder_datapath_seq.sv
// Self-checking bench for adder_datapath_seq (WIDTH=4, CNT_W=8).
module tb_adder_datapath_seq;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int SW = 2 * W + 2;

  logic          clk, rst_n, in_valid, Cin;
  logic [1:0]    mode;
  logic [W-1:0]  A, B;
  logic          in_ready, out_valid, busy, mismatch, dbg_state;
  logic [SW-1:0] S;
  logic [CW-1:0] op_count;

  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt  = '0;
  logic [SW-1:0] exp_q[$];

  adder_datapath_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .A(A), .B(B), .Cin(Cin), .S(S), .out_valid(out_valid),
    .busy(busy), .op_count(op_count), .mismatch(mismatch),
    .dbg_state_o(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic sum placed into the halves the mode uses.
  function automatic logic [SW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic [1:0] m);
    logic [W:0] sum, rip, la;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    rip = (m == 2'b00 || m == 2'b10) ? sum : '0;
    la  = (m != 2'b00) ? sum : '0;
    return {la, rip};
  endfunction

  // One complete operation; optionally pokes junk in_valid while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [1:0] m, input bit junk);
    int lat;
    logic [SW-1:0] exp_s;
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    A = a; B = b; Cin = c; mode = m; in_valid = 1'b1;
    exp_q.push_back(model(a, b, c, m));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (m[0] == 1'b0) begin
        check("busy_serial", busy, 1);
        check("ready_serial", in_ready, 0);
        if (junk) begin
          in_valid = 1'b1;
          A = W'($urandom()); B = W'($urandom()); Cin = 1'($urandom());
          mode = 2'($urandom());
        end
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end
    check("latency", lat, (m[0] ? 1 : W));
    check("out_valid", out_valid, 1);
    exp_s = exp_q.pop_front();
    exp_cnt = exp_cnt + CW'(1);
    check("S", S, exp_s);
    check("op_count", op_count, exp_cnt);
    check("mismatch", mismatch, 0);
    check("busy_done", busy, 0);
    check("ready_done", in_ready, 1);
    @(negedge clk);
    check("pulse_len", out_valid, 0);
    check("S_hold", S, exp_s);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; mode = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_S", S, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    // Directed: lookahead, ripple, both, reserved mode
    run_op(4'hF, 4'h1, 1'b1, 2'b01, 1'b0);
    check("dir_la_S", S, 10'h220);
    run_op(4'hF, 4'h1, 1'b1, 2'b00, 1'b1);
    check("dir_rip_S", S, 10'h011);
    run_op(4'hF, 4'h1, 1'b1, 2'b10, 1'b0);
    check("dir_both_S", S, 10'h231);
    run_op(4'hF, 4'h1, 1'b1, 2'b11, 1'b0);
    check("dir_res_S", S, 10'h220);

    // Back-to-back lookahead, A=1,2,3 B=1 Cin=0
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        exp_cnt = exp_cnt + CW'(1);
        check("b2b_valid", out_valid, 1);
        check("b2b_S", S, exp_q.pop_front());
        check("b2b_upper", S[SW-1:W+1], i);
        check("b2b_count", op_count, exp_cnt);
      end
      if (i < 3) begin
        check("b2b_ready", in_ready, 1);
        A = W'(i + 1); B = 4'h1; Cin = 1'b0; mode = 2'b01; in_valid = 1'b1;
        exp_q.push_back(model(W'(i + 1), 4'h1, 1'b0, 2'b01));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Exhaustive, both engines
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_op(W'(a), W'(b), 1'(c), 2'b10, 1'b0);

    // Random mix (also carries op_count through its wrap)
    for (int n = 0; n < 300; n++)
      run_op(W'($urandom()), W'($urandom()), 1'($urandom()), 2'($urandom()), 1'b1);

    // Reset during the second serial cycle
    @(negedge clk);
    A = 4'h7; B = 4'h9; Cin = 1'b1; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    exp_q.delete();
    check("midrst_S", S, 0);
    check("midrst_count", op_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_valid", out_valid, 0);
      @(negedge clk);
    end
    check("midrst_S_still", S, 0);
    run_op(4'h7, 4'h9, 1'b1, 2'b00, 1'b0);
    run_op(4'h3, 4'hC, 1'b0, 2'b10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
